bus_cycle_sequencer: RTL and testbench
======================================

# bus_cycle_sequencer

Machine-cycle and T-state sequencer for the 8085 core. Runs each machine cycle requested by the instruction controller (opcode fetch, memory/IO read/write, interrupt acknowledge, bus idle, halt) through its T-states and drives the bus control strobes and status lines. Handles READY wait states and HOLD/HLDA bus grants. Sits between the microcode/decoding logic, which issues `mc_type`, and the external bus pins.

## Interface
- No parameters; encodings are fixed in `i8085_pkg`.
- `phi1` in 1: system clock; all state changes on its rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `mc_type` in 3: type of the next machine cycle; `mc_type_t` from the package.
- `of_long` in 1: current opcode fetch needs 6 T-states instead of 4; sampled in T4 of an opcode fetch.
- `ready` in 1: memory/IO ready; sampled in T2 and in TW.
- `hold` in 1: external bus request.
- `intr_wake` in 1: leaves halt.
- `tstate` out 8: one-hot state, bits {T1,T2,T3,T4,T5,T6,TW,TRST}; exactly one bit set.
- `mc_ack` out 1: 1-cycle pulse in T1; `mc_type` was latched on this edge.
- `mc_done` out 1: 1-cycle pulse in the last T-state of a machine cycle.
- `ALE`, `RDn`, `WRn`, `IOMn`, `S0`, `S1` out 1 each: bus control and status.
- `dbus_to_instr_reg` out 1: load the instruction register; high in T3 of an opcode fetch.
- `hlda` out 1: hold acknowledge.
- `halted` out 1: sequencer is in the halt state.

## Operation
- States: TRST, T1, T2, TW, T3, T4, T5, T6, THOLD, THALT. `tstate` shows TRST for THOLD and THALT; use `hlda` and `halted` to tell them apart.
- After reset the sequencer holds TRST for one cycle, then enters T1. The first cycle is always an opcode fetch, whatever `mc_type` is.
- Entering T1: `mc_type` is latched (except for the forced first fetch) and `mc_ack` pulses.
- Cycle lengths:
  - MC_OF: T1–T4; T1–T6 if `of_long`=1 in T4.
  - MC_MR, MC_MW, MC_IOR, MC_IOW, MC_INA, MC_BI: T1–T3.
  - MC_HALT: T1, then THALT.
- Status from T1 until the cycle ends, as {IOMn,S1,S0}: OF 011, MR 010, MW 001, IOR 110, IOW 101, INA 111, BI 000, HALT 000.
- Strobes:
  - `ALE`=1 only in T1, and not for BI.
  - `RDn`=0 in T2, TW and T3 for OF, MR, IOR and INA.
  - `WRn`=0 in T2, TW and T3 for MW and IOW.
  - BI drives no strobes.
- Wait states: in T2, `ready`=0 goes to TW and `ready`=1 goes to T3. In TW, the sequencer stays while `ready`=0. BI and HALT ignore `ready`.
- Hold:
  - `hold` is sampled in T2 and TW of any cycle and latched as `hold_pend`.
  - After the last T-state of the cycle, a pending hold goes to THOLD instead of T1.
  - In THOLD, `hlda`=1 and RDn/WRn/ALE/status are inactive. `hold`=0 returns to T1.
- Halt:
  - THALT stays until `intr_wake`=1, then goes to T1.
  - `hold`=1 in THALT sets `hlda`=1 without leaving THALT; `hlda` drops the cycle after `hold`=0.
- Reset mid-cycle aborts immediately; nothing is completed or replayed.

## Timing
- All outputs are registered and change only on the rising edge of `phi1`. `resetn` low forces reset values asynchronously.
- Reset values:
  - `tstate`=00000001, `ALE`=0, `RDn`=1, `WRn`=1.
  - `IOMn`=0, `S1`=0, `S0`=0.
  - `mc_ack`=0, `mc_done`=0, `dbus_to_instr_reg`=0, `hlda`=0, `halted`=0.
- `mc_type` must be stable during the cycle in which `mc_done`=1; it is captured on the next edge, which enters T1.
- `of_long` is valid during T4 of an OF.
- Zero-wait latencies: OF 4 or 6 cycles, other cycles 3, back to back with no gap.
- `ready` and `hold` seen in the same T2: the wait states are served first, then the hold.
- `hold` dropping in the same cycle that THOLD is entered: one THOLD cycle still occurs.

## Structure
- `i8085_pkg` holds `mc_type_t` (OF=0, MR=1, MW=2, IOR=3, IOW=4, INA=5, BI=6, HALT=7), the state enum `tstate_t`, the one-hot bit indices, and the status-encoding function.
- One sub-module, `bus_strobe_gen`: a registered decode of (next state, latched `mc_type`) into ALE/RDn/WRn/IOMn/S1/S0.
- The state register and transition logic stay in the top module.

## Test plan
- Release reset with `ready`=1 and `mc_type`=MR. Expect TRST → T1 → T4 for an OF with {IOMn,S1,S0}=011, `dbus_to_instr_reg`=1 in T3, then T1–T3 for MR with status 010.
- MW with `ready`=0 for 2 cycles after T2. Expect T1, T2, TW, TW, T3, with `WRn`=0 across T2 through T3 (4 cycles) and `mc_done` in T3.
- OF with `of_long`=1 in T4. Expect T5 and T6, `mc_done` only in T6, and the next T1 right after.
- `hold`=1 in T2 of IOR, released 3 cycles after T3. Expect THOLD for 3 cycles with `hlda`=1 and RDn=WRn=1, then T1.
- MC_HALT, then `hold` pulse, then `intr_wake`=1. Expect `halted`=1, `hlda` following `hold`, then T1 on the cycle after the wake.
- Assert `resetn` low during TW. Expect all outputs at reset values immediately, and TRST held until release.

Source files
------------

// File: rtl/i8085_pkg.sv
// Shared encodings for the 8085 bus cycle sequencer: machine-cycle types,
// internal T-state enum, one-hot bit positions of tstate and status decode.
package i8085_pkg;

  typedef enum logic [2:0] {
    MC_OF   = 3'd0,
    MC_MR   = 3'd1,
    MC_MW   = 3'd2,
    MC_IOR  = 3'd3,
    MC_IOW  = 3'd4,
    MC_INA  = 3'd5,
    MC_BI   = 3'd6,
    MC_HALT = 3'd7
  } mc_type_t;

  typedef enum logic [3:0] {
    S_TRST  = 4'd0,
    S_T1    = 4'd1,
    S_T2    = 4'd2,
    S_TW    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_THOLD = 4'd8,
    S_THALT = 4'd9
  } tstate_t;

  // Bit positions inside the one-hot tstate output {T1,T2,T3,T4,T5,T6,TW,TRST}
  localparam logic [2:0] TS_T1   = 3'd7;
  localparam logic [2:0] TS_T2   = 3'd6;
  localparam logic [2:0] TS_T3   = 3'd5;
  localparam logic [2:0] TS_T4   = 3'd4;
  localparam logic [2:0] TS_T5   = 3'd3;
  localparam logic [2:0] TS_T6   = 3'd2;
  localparam logic [2:0] TS_TW   = 3'd1;
  localparam logic [2:0] TS_TRST = 3'd0;

  // Hold and halt have no bit of their own; they show as TRST.
  function automatic logic [7:0] tstate_onehot(input tstate_t s);
    logic [7:0] oh;
    oh = 8'h00;
    case (s)
      S_T1:    oh[TS_T1] = 1'b1;
      S_T2:    oh[TS_T2] = 1'b1;
      S_T3:    oh[TS_T3] = 1'b1;
      S_T4:    oh[TS_T4] = 1'b1;
      S_T5:    oh[TS_T5] = 1'b1;
      S_T6:    oh[TS_T6] = 1'b1;
      S_TW:    oh[TS_TW] = 1'b1;
      default: oh[TS_TRST] = 1'b1;
    endcase
    return oh;
  endfunction

  // Status lines {IOMn,S1,S0} for an active machine cycle.
  function automatic logic [2:0] status_enc(input mc_type_t mc);
    logic [2:0] st;
    case (mc)
      MC_OF:   st = 3'b011;
      MC_MR:   st = 3'b010;
      MC_MW:   st = 3'b001;
      MC_IOR:  st = 3'b110;
      MC_IOW:  st = 3'b101;
      MC_INA:  st = 3'b111;
      MC_BI:   st = 3'b000;
      default: st = 3'b000;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/bus_strobe_gen.sv
// Registered decode of the upcoming T-state and cycle type into the bus
// control strobes and status lines, so the pins change only on the clock edge.
module bus_strobe_gen
  import i8085_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  tstate_t  state_d_i,
  input  mc_type_t mc_d_i,
  output logic     ale_o,
  output logic     rd_n_o,
  output logic     wr_n_o,
  output logic     iom_n_o,
  output logic     s1_o,
  output logic     s0_o
);

  logic       ale_d, rd_n_d, wr_n_d;
  logic [2:0] status_d;
  logic       ale_q, rd_n_q, wr_n_q;
  logic [2:0] status_q;
  logic       is_read_s, is_write_s;

  // Strobe and status values for the state about to be entered.
  always_comb begin
    ale_d      = 1'b0;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    status_d   = 3'b000;
    is_read_s  = 1'b0;
    is_write_s = 1'b0;
    case (mc_d_i)
      MC_OF, MC_MR, MC_IOR, MC_INA: is_read_s  = 1'b1;
      MC_MW, MC_IOW:                is_write_s = 1'b1;
      default: begin
        is_read_s  = 1'b0;
        is_write_s = 1'b0;
      end
    endcase
    case (state_d_i)
      S_T1: begin
        ale_d    = (mc_d_i != MC_BI);
        status_d = status_enc(mc_d_i);
      end
      S_T2, S_TW, S_T3: begin
        status_d = status_enc(mc_d_i);
        rd_n_d   = ~is_read_s;
        wr_n_d   = ~is_write_s;
      end
      S_T4, S_T5, S_T6: status_d = status_enc(mc_d_i);
      default: begin
        ale_d    = 1'b0;
        status_d = 3'b000;
      end
    endcase
  end

  // Output registers; reset leaves the bus idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ale_q    <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      status_q <= 3'b000;
    end else begin
      ale_q    <= ale_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      status_q <= status_d;
    end
  end

  assign ale_o   = ale_q;
  assign rd_n_o  = rd_n_q;
  assign wr_n_o  = wr_n_q;
  assign iom_n_o = status_q[2];
  assign s1_o    = status_q[1];
  assign s0_o    = status_q[0];

endmodule

// File: rtl/bus_cycle_sequencer.sv
// 8085 machine-cycle / T-state sequencer: steps each requested machine cycle
// through its T-states, inserts READY wait states, and handles HOLD and HALT.
module bus_cycle_sequencer
  import i8085_pkg::*;
(
  input  logic       phi1,
  input  logic       resetn,
  input  mc_type_t   mc_type,
  input  logic       of_long,
  input  logic       ready,
  input  logic       hold,
  input  logic       intr_wake,
  output logic [7:0] tstate,
  output logic       mc_ack,
  output logic       mc_done,
  output logic       ALE,
  output logic       RDn,
  output logic       WRn,
  output logic       IOMn,
  output logic       S0,
  output logic       S1,
  output logic       dbus_to_instr_reg,
  output logic       hlda,
  output logic       halted
);

  tstate_t    state_q, state_d;
  mc_type_t   mc_q, mc_d;
  logic       hold_pend_q, hold_pend_d;
  tstate_t    cycle_next_s;
  logic [7:0] tstate_q;
  logic       mc_ack_q, mc_done_q, dbus_q, hlda_q, halted_q;

  // Next T-state, latched cycle type and pending-hold flag.
  always_comb begin
    state_d      = state_q;
    mc_d         = mc_q;
    hold_pend_d  = hold_pend_q;
    cycle_next_s = hold_pend_q ? S_THOLD : S_T1;
    case (state_q)
      S_TRST:  state_d = S_T1;
      S_T1:    state_d = (mc_q == MC_HALT) ? S_THALT : S_T2;
      S_T2: begin
        if ((mc_q == MC_BI) || ready) state_d = S_T3;
        else                          state_d = S_TW;
      end
      S_TW:    state_d = ready ? S_T3 : S_TW;
      S_T3:    state_d = (mc_q == MC_OF) ? S_T4 : cycle_next_s;
      S_T4:    state_d = of_long ? S_T5 : cycle_next_s;
      S_T5:    state_d = S_T6;
      S_T6:    state_d = cycle_next_s;
      S_THOLD: state_d = hold ? S_THOLD : S_T1;
      S_THALT: state_d = intr_wake ? S_T1 : S_THALT;
      default: state_d = S_TRST;
    endcase
    if ((state_q == S_T2) || (state_q == S_TW)) begin
      hold_pend_d = hold_pend_q | hold;
    end else if (state_d == S_THOLD) begin
      hold_pend_d = 1'b0;
    end else begin
      hold_pend_d = hold_pend_q;
    end
    // The first cycle after reset is always a fetch, whatever is requested.
    if (state_d == S_T1) begin
      mc_d = (state_q == S_TRST) ? MC_OF : mc_type;
    end else begin
      mc_d = mc_q;
    end
  end

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge phi1 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_TRST;
      mc_q        <= MC_OF;
      hold_pend_q <= 1'b0;
      tstate_q    <= 8'h01;
      mc_ack_q    <= 1'b0;
      mc_done_q   <= 1'b0;
      dbus_q      <= 1'b0;
      hlda_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mc_q        <= mc_d;
      hold_pend_q <= hold_pend_d;
      tstate_q    <= tstate_onehot(state_d);
      mc_ack_q    <= (state_d == S_T1);
      mc_done_q   <= ((state_d == S_T3) && (mc_d != MC_OF)) ||
                     (state_d == S_T6) ||
                     ((state_d == S_T1) && (mc_d == MC_HALT));
      dbus_q      <= (state_d == S_T3) && (mc_d == MC_OF);
      hlda_q      <= (state_d == S_THOLD) || ((state_d == S_THALT) && hold);
      halted_q    <= (state_d == S_THALT);
    end
  end

  bus_strobe_gen u_strobe (
    .clk_i     (phi1),
    .rst_ni    (resetn),
    .state_d_i (state_d),
    .mc_d_i    (mc_d),
    .ale_o     (ALE),
    .rd_n_o    (RDn),
    .wr_n_o    (WRn),
    .iom_n_o   (IOMn),
    .s1_o      (S1),
    .s0_o      (S0)
  );

  assign tstate            = tstate_q;
  assign mc_ack            = mc_ack_q;
  // A short fetch ends in T4, but of_long only becomes valid during T4 itself,
  // so that one completion is decoded from the current state and of_long.
  assign mc_done           = mc_done_q | ((state_q == S_T4) & ~of_long);
  assign dbus_to_instr_reg = dbus_q;
  assign hlda              = hlda_q;
  assign halted            = halted_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed cycle-by-cycle bench for bus_cycle_sequencer with hand-computed
// expected outputs for every cycle.
module tb_bus_cycle_sequencer;
  import i8085_pkg::*;

  logic       phi1 = 1'b0;
  logic       resetn = 1'b1;
  mc_type_t   mc_type = MC_MR;
  logic       of_long = 1'b0;
  logic       ready = 1'b1;
  logic       hold = 1'b0;
  logic       intr_wake = 1'b0;
  logic [7:0] tstate;
  logic       mc_ack, mc_done, ALE, RDn, WRn, IOMn, S0, S1;
  logic       dbus_to_instr_reg, hlda, halted;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [7:0] T1 = 8'h80;
  localparam logic [7:0] T2 = 8'h40;
  localparam logic [7:0] T3 = 8'h20;
  localparam logic [7:0] T4 = 8'h10;
  localparam logic [7:0] T5 = 8'h08;
  localparam logic [7:0] T6 = 8'h04;
  localparam logic [7:0] TW = 8'h02;
  localparam logic [7:0] TR = 8'h01;

  always #5 phi1 = ~phi1;

  bus_cycle_sequencer dut (
    .phi1              (phi1),
    .resetn            (resetn),
    .mc_type           (mc_type),
    .of_long           (of_long),
    .ready             (ready),
    .hold              (hold),
    .intr_wake         (intr_wake),
    .tstate            (tstate),
    .mc_ack            (mc_ack),
    .mc_done           (mc_done),
    .ALE               (ALE),
    .RDn               (RDn),
    .WRn               (WRn),
    .IOMn              (IOMn),
    .S0                (S0),
    .S1                (S1),
    .dbus_to_instr_reg (dbus_to_instr_reg),
    .hlda              (hlda),
    .halted            (halted)
  );

  logic [18:0] obs;
  assign obs = {tstate, mc_ack, mc_done, ALE, RDn, WRn, IOMn, S1, S0,
                dbus_to_instr_reg, hlda, halted};

  // Expected word: {tstate, ack, done, ALE, RDn, WRn, {IOMn,S1,S0}, dbus, hlda, halted}
  function automatic logic [18:0] w(input logic [7:0] ts, input logic ack,
                                    input logic done, input logic ale,
                                    input logic rd, input logic wr,
                                    input logic [2:0] st, input logic db,
                                    input logic ha, input logic hl);
    return {ts, ack, done, ale, rd, wr, st, db, ha, hl};
  endfunction

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check that cycle's outputs, advance one clock.
  task automatic cyc(input string tag, input logic rn, input mc_type_t mt,
                     input logic ol, input logic rdy, input logic hd,
                     input logic iw, input logic [18:0] exp);
    resetn    = rn;
    mc_type   = mt;
    of_long   = ol;
    ready     = rdy;
    hold      = hd;
    intr_wake = iw;
    #1;
    chk(tag, obs, exp);
    @(posedge phi1);
    #1;
  endtask

  logic [18:0] rst_w;

  initial begin
    rst_w = w(TR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    #1 resetn = 1'b0;
    @(posedge phi1);
    #1;
    // Reset, forced first fetch, then MR
    cyc("reset",    1'b0, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, rst_w);
    cyc("trst",     1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, rst_w);
    cyc("of_t1",    1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T1, 1, 0, 1, 1, 1, 3'b011, 0, 0, 0));
    cyc("of_t2",    1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T2, 0, 0, 0, 0, 1, 3'b011, 0, 0, 0));
    cyc("of_t3",    1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T3, 0, 0, 0, 0, 1, 3'b011, 1, 0, 0));
    cyc("of_t4",    1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T4, 0, 1, 0, 1, 1, 3'b011, 0, 0, 0));
    cyc("mr_t1",    1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T1, 1, 0, 1, 1, 1, 3'b010, 0, 0, 0));
    cyc("mr_t2",    1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T2, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0));
    cyc("mr_t3",    1'b1, MC_MW, 1'b0, 1'b1, 1'b0, 1'b0, w(T3, 0, 1, 0, 0, 1, 3'b010, 0, 0, 0));
    // MW with two wait states
    cyc("mw_t1",    1'b1, MC_MW, 1'b0, 1'b1, 1'b0, 1'b0, w(T1, 1, 0, 1, 1, 1, 3'b001, 0, 0, 0));
    cyc("mw_t2",    1'b1, MC_MW, 1'b0, 1'b0, 1'b0, 1'b0, w(T2, 0, 0, 0, 1, 0, 3'b001, 0, 0, 0));
    cyc("mw_tw1",   1'b1, MC_MW, 1'b0, 1'b0, 1'b0, 1'b0, w(TW, 0, 0, 0, 1, 0, 3'b001, 0, 0, 0));
    cyc("mw_tw2",   1'b1, MC_MW, 1'b0, 1'b1, 1'b0, 1'b0, w(TW, 0, 0, 0, 1, 0, 3'b001, 0, 0, 0));
    cyc("mw_t3",    1'b1, MC_OF, 1'b0, 1'b1, 1'b0, 1'b0, w(T3, 0, 1, 0, 1, 0, 3'b001, 0, 0, 0));
    // Six-state opcode fetch
    cyc("ofl_t1",   1'b1, MC_OF, 1'b0, 1'b1, 1'b0, 1'b0, w(T1, 1, 0, 1, 1, 1, 3'b011, 0, 0, 0));
    cyc("ofl_t2",   1'b1, MC_OF, 1'b0, 1'b1, 1'b0, 1'b0, w(T2, 0, 0, 0, 0, 1, 3'b011, 0, 0, 0));
    cyc("ofl_t3",   1'b1, MC_OF, 1'b0, 1'b1, 1'b0, 1'b0, w(T3, 0, 0, 0, 0, 1, 3'b011, 1, 0, 0));
    cyc("ofl_t4",   1'b1, MC_OF, 1'b1, 1'b1, 1'b0, 1'b0, w(T4, 0, 0, 0, 1, 1, 3'b011, 0, 0, 0));
    cyc("ofl_t5",   1'b1, MC_OF, 1'b0, 1'b1, 1'b0, 1'b0, w(T5, 0, 0, 0, 1, 1, 3'b011, 0, 0, 0));
    cyc("ofl_t6",   1'b1, MC_IOR, 1'b0, 1'b1, 1'b0, 1'b0, w(T6, 0, 1, 0, 1, 1, 3'b011, 0, 0, 0));
    // IOR with hold requested in T2, three hold cycles
    cyc("ior_t1",   1'b1, MC_IOR, 1'b0, 1'b1, 1'b0, 1'b0, w(T1, 1, 0, 1, 1, 1, 3'b110, 0, 0, 0));
    cyc("ior_t2",   1'b1, MC_IOR, 1'b0, 1'b1, 1'b1, 1'b0, w(T2, 0, 0, 0, 0, 1, 3'b110, 0, 0, 0));
    cyc("ior_t3",   1'b1, MC_IOR, 1'b0, 1'b1, 1'b1, 1'b0, w(T3, 0, 1, 0, 0, 1, 3'b110, 0, 0, 0));
    cyc("thold1",   1'b1, MC_HALT, 1'b0, 1'b1, 1'b1, 1'b0, w(TR, 0, 0, 0, 1, 1, 3'b000, 0, 1, 0));
    cyc("thold2",   1'b1, MC_HALT, 1'b0, 1'b1, 1'b1, 1'b0, w(TR, 0, 0, 0, 1, 1, 3'b000, 0, 1, 0));
    cyc("thold3",   1'b1, MC_HALT, 1'b0, 1'b1, 1'b0, 1'b0, w(TR, 0, 0, 0, 1, 1, 3'b000, 0, 1, 0));
    // Halt, hold pulse inside halt, wake
    cyc("halt_t1",  1'b1, MC_HALT, 1'b0, 1'b1, 1'b0, 1'b0, w(T1, 1, 1, 1, 1, 1, 3'b000, 0, 0, 0));
    cyc("thalt1",   1'b1, MC_HALT, 1'b0, 1'b1, 1'b0, 1'b0, w(TR, 0, 0, 0, 1, 1, 3'b000, 0, 0, 1));
    cyc("thalt2",   1'b1, MC_HALT, 1'b0, 1'b1, 1'b1, 1'b0, w(TR, 0, 0, 0, 1, 1, 3'b000, 0, 0, 1));
    cyc("thalt_ha", 1'b1, MC_HALT, 1'b0, 1'b1, 1'b1, 1'b0, w(TR, 0, 0, 0, 1, 1, 3'b000, 0, 1, 1));
    cyc("thalt_hb", 1'b1, MC_HALT, 1'b0, 1'b1, 1'b0, 1'b0, w(TR, 0, 0, 0, 1, 1, 3'b000, 0, 1, 1));
    cyc("thalt_wk", 1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b1, w(TR, 0, 0, 0, 1, 1, 3'b000, 0, 0, 1));
    cyc("wake_t1",  1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T1, 1, 0, 1, 1, 1, 3'b010, 0, 0, 0));
    cyc("mr2_t2",   1'b1, MC_MR, 1'b0, 1'b0, 1'b0, 1'b0, w(T2, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0));
    // Asynchronous reset in the middle of a wait state
    resetn  = 1'b1;
    mc_type = MC_MR;
    ready   = 1'b0;
    #1;
    chk("mr2_tw", obs, w(TW, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0));
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst", obs, rst_w);
    @(posedge phi1);
    #1;
    cyc("rst_held", 1'b0, MC_MR, 1'b0, 1'b0, 1'b0, 1'b0, rst_w);
    cyc("rst_rel",  1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, rst_w);
    cyc("of2_t1",   1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T1, 1, 0, 1, 1, 1, 3'b011, 0, 0, 0));
    cyc("of2_t2",   1'b1, MC_MR, 1'b0, 1'b1, 1'b0, 1'b0, w(T2, 0, 0, 0, 0, 1, 3'b011, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
